mem_array: RTL and testbench

//   Read-only 8x8 single-bit memory array addressed by row/column.

---
 rtl/mem_array.sv | 58 +++++
 tb/tb_mem_array.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
//   Read-only ROWS x COLS single-bit lookup/bitmap store. The contents are
//   loaded from the INIT pattern while reset is held and never change after
//   that. One cell is read on every rising clock edge into a registered
//   1-bit output, so data appears one cycle after its address is sampled.
//
// Parameters
//   ROW_W  row address width    (ROWS = 2**ROW_W)
//   COL_W  column address width (COLS = 2**COL_W)
//   INIT   reset contents, cell(r,c) = INIT[r*COLS + c]
//
// Ports
//   _clock   in   1      rising-edge clock
//   _reset   in   1      asynchronous active-low reset (reloads INIT, clears _value)
//   _row     in   ROW_W  row address, sampled at the rising edge
//   _column  in   COL_W  column address, sampled at the rising edge
//   _value   out  1      registered contents of the addressed cell
// -----------------------------------------------------------------------------
module mem_array #(
    parameter int unsigned ROW_W = 3,
    parameter int unsigned COL_W = 3,
    parameter logic [(2**(ROW_W+COL_W))-1:0] INIT = 64'h55AA_55AA_55AA_55AA
) (
    input  logic             _clock,
    input  logic             _reset,
    input  logic [ROW_W-1:0] _row,
    input  logic [COL_W-1:0] _column,
    output logic             _value
);

    localparam int unsigned CELLS = 2**(ROW_W+COL_W);

    // Flat storage; cell(r,c) lives at bit r*COLS + c.
    logic [CELLS-1:0]         cells;
    logic [ROW_W+COL_W-1:0]   index;

    // COLS is a power of two, so r*COLS + c is just the concatenation.
    always_comb begin
        index = {_row, _column};
    end

    // No write path: the array only ever takes INIT, and otherwise holds.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            cells <= INIT;
        end
    end

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            _value <= 1'b0;
        end else begin
            _value <= cells[index];
        end
    end

endmodule

// File: tb/tb_mem_array.sv
module tb_mem_array;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] row   = 3'd0;
    logic [2:0] col   = 3'd0;
    logic       val_def;
    logic       val_cor;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural expectations for each instance.
    bit m_def = 1'b0;
    bit m_cor = 1'b0;

    mem_array dut_def (
        ._clock  (clk),
        ._reset  (rst_n),
        ._row    (row),
        ._column (col),
        ._value  (val_def)
    );

    mem_array #(
        .INIT (64'h8000_0000_0000_0001)
    ) dut_cor (
        ._clock  (clk),
        ._reset  (rst_n),
        ._row    (row),
        ._column (col),
        ._value  (val_cor)
    );

    always #10 clk = ~clk;

    // Checkerboard: a cell is set when row + column is odd.
    function automatic bit exp_default(input int r, input int c);
        return ((r + c) % 2) == 1;
    endfunction

    // Corner pattern: only the first and the last cell are set.
    function automatic bit exp_corner(input int r, input int c);
        return (r == 0 && c == 0) || (r == 7 && c == 7);
    endfunction

    task automatic check(input string name, input bit actual, input bit expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: a read lands at every rising edge out of reset; reset clears at once.
    always @(posedge clk) begin
        if (rst_n) begin
            m_def = exp_default(int'(row), int'(col));
            m_cor = exp_corner(int'(row), int'(col));
        end else begin
            m_def = 1'b0;
            m_cor = 1'b0;
        end
    end

    always @(negedge rst_n) begin
        m_def = 1'b0;
        m_cor = 1'b0;
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_default", val_def, m_def);
            check("cycle_corner", val_cor, m_cor);
        end
    end

    // Present an address, let one rising edge sample it, return 2 units later.
    task automatic step(input int r, input int c);
        row = 3'(r);
        col = 3'(c);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1;
        chk_en = 1'b1;

        // Reset held: output stays 0 across edges.
        row = 3'd0; col = 3'd1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_hold_def", val_def, 1'b0);
        check("reset_hold_cor", val_cor, 1'b0);

        // Release between edges; first edge is a normal read.
        rst_n = 1'b1;
        step(1, 5);
        check("r1c5", val_def, 1'b0);
        step(3, 2);
        check("r3c2", val_def, 1'b1);
        step(6, 0);
        check("r6c0", val_def, 1'b0);
        step(0, 1);
        check("r0c1", val_def, 1'b1);

        // Async reset between edges clears the output without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_def", val_def, 1'b0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Corner-pattern instance pinned by hand.
        step(0, 0);
        check("cor_r0c0", val_cor, 1'b1);
        check("def_r0c0", val_def, 1'b0);
        step(7, 7);
        check("cor_r7c7", val_cor, 1'b1);
        step(7, 6);
        check("cor_r7c6", val_cor, 1'b0);
        check("def_r7c6", val_def, 1'b1);
        step(0, 1);
        check("cor_r0c1", val_cor, 1'b0);

        // Address change between edges has no effect until the next edge.
        step(2, 3);
        check("r2c3", val_def, 1'b1);
        row = 3'd2; col = 3'd2;
        #4;
        check("midcycle_hold", val_def, 1'b1);
        @(posedge clk);
        #2;
        check("midcycle_next", val_def, 1'b0);

        // Full sweep, with one reset pulse in the middle.
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                step(r, c);
                if (r == 4 && c == 3) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check("sweep_reset_def", val_def, 1'b0);
                    check("sweep_reset_cor", val_cor, 1'b0);
                    #1;
                    rst_n = 1'b1;
                end
            end
        end
        step(5, 2);
        check("after_sweep_r5c2", val_def, 1'b1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
